// File: rtl/lock_pkg.sv
// Shared definitions for the chamber lock sequencer.
//   lock_state_e : 3-bit FSM state encodings (codes 6 and 7 are illegal)
//   DIR_UP/DOWN  : travel direction latched when leaving an idle state
//   hold_w()     : width of the gate-hold down-counter for a given hold length
package lock_pkg;

  typedef enum logic [2:0] {
    StIdleLow  = 3'd0,
    StOpenLow  = 3'd1,
    StFill     = 3'd2,
    StOpenHigh = 3'd3,
    StDrain    = 3'd4,
    StIdleHigh = 3'd5
  } lock_state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned HOLD_CYCLES_DEFAULT = 4;

  function automatic int unsigned hold_w(input int unsigned hold_cycles);
    return $clog2(hold_cycles + 1);
  endfunction

  localparam int unsigned HOLD_W = hold_w(HOLD_CYCLES_DEFAULT);

endpackage

// File: rtl/gate_hold_timer.sv
// Gate-hold down-counter: keeps a gate open for HOLD_CYCLES unobstructed cycles.
//   clock, reset : system clock, asynchronous active-high reset
//   load_i       : reload HOLD_CYCLES-1 (asserted on the edge that opens a gate)
//   freeze_i     : boat in the gateway; count holds
//   expired_o    : count is zero and the gateway is clear
module gate_hold_timer
  import lock_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic freeze_i,
  output logic expired_o
);

  localparam int unsigned HoldW = hold_w(HOLD_CYCLES);
  localparam logic [HoldW-1:0] LoadVal = HoldW'(HOLD_CYCLES - 1);

  logic [HoldW-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LoadVal;
    end else if (!freeze_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - HoldW'(1);
    end
  end

  assign expired_o = (cnt_q == '0) && !freeze_i;

endmodule

// File: rtl/lock_sequencer.sv
// Chamber lock sequencer: moves boats up or down by sequencing the low/high gates and
// the fill/drain valves as a Moore FSM. Outputs are registered decodes of the state.
//   clock, reset          : system clock, asynchronous active-high reset
//   req_up_i, req_down_i  : boat waiting at low / high side (sampled only when idle)
//   obstruct_i            : boat in an open gateway, freezes the gate hold
//   timer_done_i          : held done level from the external phase timer
//   timer_clr_o           : one-cycle restart pulse for the phase timer
//   gate_*_open_o, fill_valve_o, drain_valve_o : mutually exclusive actuators
//   level_high_o, busy_o, state_o             : status and debug
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_up_i,
  input  logic       req_down_i,
  input  logic       obstruct_i,
  input  logic       timer_done_i,
  output logic       timer_clr_o,
  output logic       gate_low_open_o,
  output logic       gate_high_open_o,
  output logic       fill_valve_o,
  output logic       drain_valve_o,
  output logic       level_high_o,
  output logic       busy_o,
  output logic [2:0] state_o
);

  lock_state_e state_q, state_d;
  logic        dir_q, dir_d;
  // Age within FILL/DRAIN: 0 = clear cycle, 1 = guard cycle, 2 = done is trusted.
  logic [1:0]  age_q, age_d;
  logic        entering;
  logic        hold_load;
  logic        hold_expired;
  logic        phase_start;

  logic timer_clr_q, gate_low_q, gate_high_q, fill_q, drain_q, level_high_q, busy_q;

  gate_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold (
    .clock    (clock),
    .reset    (reset),
    .load_i   (hold_load),
    .freeze_i (obstruct_i),
    .expired_o(hold_expired)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      StIdleLow: begin
        if (req_up_i) begin
          state_d = StOpenLow;
          dir_d   = DIR_UP;
        end else if (req_down_i) begin
          state_d = StFill;
          dir_d   = DIR_DOWN;
        end
      end
      StIdleHigh: begin
        if (req_down_i) begin
          state_d = StOpenHigh;
          dir_d   = DIR_DOWN;
        end else if (req_up_i) begin
          state_d = StDrain;
          dir_d   = DIR_UP;
        end
      end
      StOpenLow: begin
        if (hold_expired) state_d = (dir_q == DIR_UP) ? StFill : StIdleLow;
      end
      StOpenHigh: begin
        if (hold_expired) state_d = (dir_q == DIR_DOWN) ? StDrain : StIdleHigh;
      end
      StFill: begin
        if ((age_q == 2'd2) && timer_done_i) state_d = StOpenHigh;
      end
      StDrain: begin
        if ((age_q == 2'd2) && timer_done_i) state_d = StOpenLow;
      end
      default: state_d = StIdleLow;
    endcase
  end

  always_comb begin
    entering    = (state_d != state_q);
    hold_load   = entering && ((state_d == StOpenLow) || (state_d == StOpenHigh));
    phase_start = entering && ((state_d == StFill) || (state_d == StDrain));
    if (entering) begin
      age_d = 2'd0;
    end else if (age_q == 2'd2) begin
      age_d = 2'd2;
    end else begin
      age_d = age_q + 2'd1;
    end
  end

  // Outputs are registered from the next state so they change on the same edge as
  // the state register and have no combinational path from the inputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdleLow;
      dir_q        <= DIR_DOWN;
      age_q        <= 2'd0;
      timer_clr_q  <= 1'b0;
      gate_low_q   <= 1'b0;
      gate_high_q  <= 1'b0;
      fill_q       <= 1'b0;
      drain_q      <= 1'b0;
      level_high_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      age_q        <= age_d;
      timer_clr_q  <= phase_start;
      gate_low_q   <= (state_d == StOpenLow);
      gate_high_q  <= (state_d == StOpenHigh);
      fill_q       <= (state_d == StFill);
      drain_q      <= (state_d == StDrain);
      level_high_q <= (state_d == StOpenHigh) || (state_d == StIdleHigh);
      busy_q       <= (state_d != StIdleLow) && (state_d != StIdleHigh);
    end
  end

  assign timer_clr_o      = timer_clr_q;
  assign gate_low_open_o  = gate_low_q;
  assign gate_high_open_o = gate_high_q;
  assign fill_valve_o     = fill_q;
  assign drain_valve_o    = drain_q;
  assign level_high_o     = level_high_q;
  assign busy_o           = busy_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
module tb_lock_sequencer;

  localparam int unsigned Hold = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_up = 1'b0, req_down = 1'b0, obstruct = 1'b0, timer_done = 1'b0;
  logic       timer_clr_o, gate_low_open_o, gate_high_open_o, fill_valve_o, drain_valve_o;
  logic       level_high_o, busy_o;
  logic [2:0] state_o;

  lock_sequencer #(
    .HOLD_CYCLES(Hold)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_up_i        (req_up),
    .req_down_i      (req_down),
    .obstruct_i      (obstruct),
    .timer_done_i    (timer_done),
    .timer_clr_o     (timer_clr_o),
    .gate_low_open_o (gate_low_open_o),
    .gate_high_open_o(gate_high_open_o),
    .fill_valve_o    (fill_valve_o),
    .drain_valve_o   (drain_valve_o),
    .level_high_o    (level_high_o),
    .busy_o          (busy_o),
    .state_o         (state_o)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: where the chamber is, which way the boat travels, how long the
  // current phase has lasted and how many of those cycles the gateway was blocked.
  // 0 low idle, 1 low gate open, 2 filling, 3 high gate open, 4 draining, 5 high idle.
  int m_state = 0, m_up = 0, m_age = 0, m_blocked = 0;

  task automatic model_edge();
    int nxt;
    if (reset) begin
      m_state = 0; m_up = 0; m_age = 0; m_blocked = 0;
      return;
    end
    nxt = m_state;
    if (m_state == 0) begin
      if (req_up) begin nxt = 1; m_up = 1; end
      else if (req_down) begin nxt = 2; m_up = 0; end
    end else if (m_state == 5) begin
      if (req_down) begin nxt = 3; m_up = 0; end
      else if (req_up) begin nxt = 4; m_up = 1; end
    end else if (m_state == 1 || m_state == 3) begin
      // Gate closes once it has been open Hold clear cycles, counting this one.
      if (!obstruct && (m_age - m_blocked + 1 >= Hold)) begin
        if (m_state == 1) nxt = m_up ? 2 : 0;
        else nxt = m_up ? 5 : 4;
      end
    end else begin
      // Phase ends on the first done seen at or after the third cycle.
      if (m_age >= 2 && timer_done) nxt = (m_state == 2) ? 3 : 1;
    end
    if (nxt != m_state) begin
      m_state = nxt; m_age = 0; m_blocked = 0;
    end else begin
      m_age++;
      if (obstruct && (m_state == 1 || m_state == 3)) m_blocked++;
    end
  endtask

  function automatic logic [6:0] exp_outs();
    logic [6:0] v;
    v[0] = (m_state == 2 || m_state == 4) && (m_age == 0);
    v[1] = (m_state == 1);
    v[2] = (m_state == 3);
    v[3] = (m_state == 2);
    v[4] = (m_state == 4);
    v[5] = (m_state == 3 || m_state == 5);
    v[6] = !(m_state == 0 || m_state == 5);
    return v;
  endfunction

  function automatic logic [6:0] obs_outs();
    return {busy_o, level_high_o, drain_valve_o, fill_valve_o, gate_high_open_o,
            gate_low_open_o, timer_clr_o};
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("state", 32'(state_o), 32'(m_state));
    check("outs", 32'(obs_outs()), 32'(exp_outs()));
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
    int n = 0;
    while (state_o !== target && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(state_o), 32'(target));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_up = 1'b0; req_down = 1'b0; obstruct = 1'b0; timer_done = 1'b0;
    step();
    reset = 1'b0;
  endtask

  int clrs, fills, drains, lows;

  initial begin
    // Reset state.
    step();
    reset = 1'b0;

    // Up from low: 4-cycle open, fill, done 10 cycles into fill, high open, high idle.
    req_up = 1'b1;
    step();
    req_up = 1'b0;
    repeat (3) step();
    step();
    check("s1_fill_clr", 32'({fill_valve_o, timer_clr_o}), 32'h3);
    repeat (9) step();
    timer_done = 1'b1;
    wait_state(3'd3, 5, "s1_open_high");
    timer_done = 1'b0;
    wait_state(3'd5, 10, "s1_idle_high");
    check("s1_level_high", 32'(level_high_o), 32'd1);

    // Down from low with an empty chamber; done held high throughout (stale done).
    do_reset();
    clrs = 0; fills = 0; drains = 0;
    req_down = 1'b1;
    timer_done = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      req_down = 1'b0;
      if (timer_clr_o) clrs++;
      if (state_o == 3'd2) fills++;
      if (state_o == 3'd4) drains++;
      if (state_o == 3'd0) break;
    end
    timer_done = 1'b0;
    check("s2_back_low", 32'(state_o), 32'd0);
    check("s2_clr_pulses", 32'(clrs), 32'd2);
    check("s2_fill_len", 32'(fills), 32'd3);
    check("s3_drain_len", 32'(drains), 32'd3);

    // Obstructed low gate: three blocked cycles stretch the open to seven.
    req_up = 1'b1;
    step();
    req_up = 1'b0;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      if (gate_low_open_o) lows++;
      obstruct = (i < 3);
      step();
      if (!gate_low_open_o) break;
    end
    obstruct = 1'b0;
    check("s4_low_open_len", 32'(lows), 32'd7);
    timer_done = 1'b1;
    wait_state(3'd5, 40, "s4_idle_high");

    // Both requests at high idle: down wins; req_up toggling while busy is ignored.
    req_up = 1'b1;
    req_down = 1'b1;
    step();
    req_down = 1'b0;
    check("s5_both_req", 32'(state_o), 32'd3);
    for (int i = 0; i < 40 && state_o != 3'd1; i++) begin
      req_up = ~req_up;
      step();
    end
    req_up = 1'b0;
    wait_state(3'd0, 20, "s5_idle_low");
    timer_done = 1'b0;

    // Asynchronous reset in the middle of a fill.
    req_down = 1'b1;
    step();
    req_down = 1'b0;
    step();
    check("s6_in_fill", 32'(state_o), 32'd2);
    #2 reset = 1'b1;
    #1;
    check("s6_async_state", 32'(state_o), 32'd0);
    check("s6_async_outs", 32'(obs_outs()), 32'd0);
    m_state = 0; m_up = 0; m_age = 0; m_blocked = 0;
    #1 reset = 1'b0;
    req_up = 1'b1;
    step();
    req_up = 1'b0;
    check("s6_restart", 32'(state_o), 32'd1);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      req_up     = ($urandom_range(0, 3) == 0);
      req_down   = ($urandom_range(0, 3) == 0);
      obstruct   = ($urandom_range(0, 3) == 0);
      timer_done = ($urandom_range(0, 5) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lock_sequencer.md
# lock_sequencer

Chamber sequencer for the interlock. It consumes the 50-step latched-done phase timer: it clears the timer at the start of each fill or drain and waits for the timer's held done level before moving on. It drives the low and high gates and the fill and drain valves as a mutually exclusive Moore FSM, and it takes boats up or down on request.

## Interface
Parameters:
- HOLD_CYCLES, default 4: minimum number of cycles a gate stays open. Must be ≥1.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- req_up  input  1  level; a boat at the low side wants to go up.
- req_down  input  1  level; a boat at the high side wants to go down.
- obstruct  input  1  level; a boat is in the open gateway, which freezes the gate-hold countdown.
- timer_done  input  1  held-high done from the external phase timer.
- timer_clr  output  1  one-cycle pulse that restarts the external phase timer.
- gate_low_open  output  1  low gate open.
- gate_high_open  output  1  high gate open.
- fill_valve  output  1  chamber filling.
- drain_valve  output  1  chamber draining.
- level_high  output  1  chamber is at the high level (IDLE_HIGH or OPEN_HIGH).
- busy  output  1  state is not IDLE_LOW or IDLE_HIGH.
- state  output  3  current state encoding, for debug and display.

## Operation
- States and encodings: IDLE_LOW=0, OPEN_LOW=1, FILL=2, OPEN_HIGH=3, DRAIN=4, IDLE_HIGH=5. Codes 6 and 7 are illegal and go to IDLE_LOW on the next edge.
- dir register: UP=1, DOWN=0. It is loaded only when the FSM leaves an idle state.
- Transitions from IDLE_LOW:
  - req_up goes to OPEN_LOW and sets dir=UP.
  - Else req_down goes to FILL and sets dir=DOWN, which brings the empty chamber up.
- Transitions from IDLE_HIGH:
  - req_down goes to OPEN_HIGH and sets dir=DOWN.
  - Else req_up goes to DRAIN and sets dir=UP.
- If both requests are active in an idle state, the request that needs no pre-move wins: req_up in IDLE_LOW, req_down in IDLE_HIGH.
- Requests are sampled only in idle states. They are never queued.
- OPEN_LOW exits when the hold expires: dir=UP goes to FILL, dir=DOWN goes to IDLE_LOW.
- OPEN_HIGH exits when the hold expires: dir=DOWN goes to DRAIN, dir=UP goes to IDLE_HIGH.
- FILL exits to OPEN_HIGH. DRAIN exits to OPEN_LOW.
- Gate hold:
  - The hold counter loads HOLD_CYCLES-1 on entry to an OPEN state.
  - It decrements each cycle while obstruct=0 and holds while obstruct=1.
  - The hold expires when the count is 0 and obstruct=0.
- Phase wait:
  - timer_clr=1 in the first cycle of FILL or DRAIN only.
  - timer_done is ignored in that cycle and the next (a stale done from the previous phase).
  - The FSM exits on the first later cycle with timer_done=1.
- Outputs are a pure decode of the registered state: at most one of gate_low_open, gate_high_open, fill_valve, drain_valve is high in any cycle.
- Reset (asynchronous, any time including mid-fill or with a gate open):
  - state=IDLE_LOW, dir=DOWN, hold count=0.
  - All outputs 0, including timer_clr.

## Timing
- Request sampled high at edge N means the new state and its outputs are visible after edge N. There is one cycle of latency and no combinational path from inputs to outputs.
- OPEN states last exactly HOLD_CYCLES cycles with obstruct=0. Each obstructed cycle adds one cycle.
- FILL and DRAIN last at least 3 cycles: the clear cycle, the guard cycle, then the first cycle that sees done.
- Consecutive gate or valve outputs never overlap. Each transition is a single state change at one edge.

## Structure
- Package lock_pkg:
  - state localparams (3-bit encodings above).
  - DIR_UP/DIR_DOWN.
  - HOLD_W = $clog2(HOLD_CYCLES+1).
- Sub-module gate_hold_timer:
  - Inputs: load, freeze.
  - Output: expired.
  - HOLD_W-bit down-counter, parameterized by HOLD_CYCLES.
- Top level: FSM and dir register; instantiates one gate_hold_timer. Phase-wait guard is a 2-bit age counter inside the FSM.

## Test plan
All scenarios use HOLD_CYCLES=4.
- Up from low: reset, then req_up=1 for one cycle.
  - Required path: OPEN_LOW for 4 cycles, then FILL with timer_clr in its first cycle.
  - Bench raises done 10 cycles later: OPEN_HIGH for 4 cycles, then IDLE_HIGH with level_high=1.
- Down from low (empty lift):
  - IDLE_LOW with req_down: FILL, OPEN_HIGH, DRAIN, OPEN_LOW, IDLE_LOW.
  - timer_clr pulses exactly twice.
- Stale done: timer_done held at 1 through entry to DRAIN. FSM stays in DRAIN exactly 3 cycles.
- obstruct=1 for 3 cycles during OPEN_LOW: gate_low_open lasts 7 cycles.
- Both requests at IDLE_HIGH: req_down wins (next state OPEN_HIGH). Toggling req_up while busy has no effect.
- Reset mid-FILL: asserting reset asynchronously sets state=0 and all outputs to 0 immediately. After release, req_up restarts from OPEN_LOW.
